// File: rtl/paritydecoder_pkg.sv
// Shared types and helpers for the parity decoder stream stage.
// The recovery helper is width-generic: callers zero-extend words narrower than MAX_WIDTH.
package paritydecoder_pkg;

  localparam int unsigned MAX_WIDTH = 64;
  localparam int unsigned DEF_WIDTH = 32;
  localparam logic [1:0]  OCC_FULL  = 2'd2;

  typedef struct packed {
    logic                 last;
    logic [DEF_WIDTH-1:0] data;
  } entry_t;

  // word = {d[width-2:0], p} zero-extended; the dropped MSB is the XOR of every encoded bit.
  function automatic logic [MAX_WIDTH-1:0] recover(input logic [MAX_WIDTH-1:0] word,
                                                   input int unsigned          width);
    logic [MAX_WIDTH-1:0] msb;
    msb = MAX_WIDTH'(^word) << (width - 1);
    return (word >> 1) | msb;
  endfunction

endpackage

// File: rtl/paritydecoder_skidbuf.sv
// Two-entry valid/ready buffer; the output always shows the oldest entry.
// No bypass: a word written into an empty buffer is visible after the clock edge.
module paritydecoder_skidbuf
  import paritydecoder_pkg::*;
#(
  parameter int unsigned EW = 33
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [EW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [EW-1:0] out_data,
  input  logic          out_ready
);

  logic [EW-1:0] ent_q [2];
  logic          head_q;
  logic [1:0]    occ_q, occ_d;
  logic          in_ready_q;
  logic          push, pop, wr_idx;

  assign push      = in_valid && in_ready_q;
  assign pop       = (occ_q != 2'd0) && out_ready;
  // With one entry held, the new word goes behind it (also when the head pops this cycle).
  assign wr_idx    = head_q ^ (occ_q != 2'd0);
  assign in_ready  = in_ready_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = ent_q[head_q];

  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (pop && !push) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      ent_q[0]   <= '0;
      ent_q[1]   <= '0;
      head_q     <= 1'b0;
      occ_q      <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) begin
        ent_q[wr_idx] <= in_data;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      occ_q      <= occ_d;
      in_ready_q <= (occ_d != OCC_FULL);
    end
  end

endmodule

// File: rtl/paritydecoder_stream.sv
// Parity decoder stream: recovers the dropped MSB, frames words, buffers them and
// produces a per-frame XOR signature at input acceptance.
module paritydecoder_stream
  import paritydecoder_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sig_valid,
  output logic [WIDTH-1:0] sig_data,
  output logic [15:0]      word_count
);

  localparam int unsigned FCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [WIDTH-1:0]  rec_data;
  logic [WIDTH:0]    buf_out;
  logic              in_fire, out_fire, is_last;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  sig_data_q, sig_data_d;
  logic              sig_valid_q, sig_valid_d;
  logic [15:0]       word_count_q, word_count_d;

  assign rec_data = WIDTH'(recover(MAX_WIDTH'(in_data), WIDTH));
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign is_last  = (fcnt_q == FCNT_W'(FRAME_LEN - 1));

  paritydecoder_skidbuf #(
    .EW (WIDTH + 1)
  ) u_skidbuf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   ({is_last, rec_data}),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (buf_out),
    .out_ready (out_ready)
  );

  assign out_last   = buf_out[WIDTH];
  assign out_data   = buf_out[WIDTH-1:0];
  assign sig_valid  = sig_valid_q;
  assign sig_data   = sig_data_q;
  assign word_count = word_count_q;

  always_comb begin
    fcnt_d       = fcnt_q;
    acc_d        = acc_q;
    sig_data_d   = sig_data_q;
    sig_valid_d  = 1'b0;
    word_count_d = word_count_q;
    if (in_fire) begin
      if (is_last) begin
        fcnt_d      = '0;
        acc_d       = '0;
        sig_data_d  = acc_q ^ rec_data;
        sig_valid_d = 1'b1;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
        acc_d  = acc_q ^ rec_data;
      end
    end
    if (out_fire) begin
      word_count_d = word_count_q + 16'd1;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      fcnt_q       <= '0;
      acc_q        <= '0;
      sig_data_q   <= '0;
      sig_valid_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      fcnt_q       <= fcnt_d;
      acc_q        <= acc_d;
      sig_data_q   <= sig_data_d;
      sig_valid_q  <= sig_valid_d;
      word_count_q <= word_count_d;
    end
  end

endmodule
